div_iter: RTL and testbench
===========================

DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 SHALL have parameter D_W, default 32, meaning operand/result width (>=4).
REQ-002 SHALL have parameter TAG_W, default 4, meaning width of the pass-through request tag.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports in_valid  input  1, and in_ready  output  1, forming the request handshake.
REQ-006 SHALL have ports dividend  input  D_W, divisor  input  D_W, and in_tag  input  TAG_W.
REQ-007 SHALL have ports out_valid  output  1, and out_ready  input  1, forming the result handshake.
REQ-008 SHALL have ports quotient  output  D_W, remainder  output  D_W, out_tag  output  TAG_W, and div_by_zero  output  1.

Function
REQ-009 SHALL implement an FSM with states IDLE, LOAD, ITER, and DONE.
REQ-010 SHALL assert in_ready only in IDLE; a request is accepted on a cycle where in_valid && in_ready, and operands and tag are registered.
REQ-011 SHALL, in LOAD, compute n = index of the highest set bit of dividend + 1 (n=0 when dividend==0) via the sub-module, then enter ITER if n>0 and divisor!=0, else DONE.
REQ-012 SHALL, in ITER, perform one radix-2 restoring step per cycle, MSB first over dividend bits n-1..0:
- partial remainder (D_W+1 bits) = partial remainder shifted left by 1, with the next dividend bit shifted in.
- if the partial remainder >= divisor, subtract divisor and set the quotient bit.
REQ-013 SHALL leave ITER after exactly n cycles.
REQ-014 SHALL have latency: with the accept cycle as cycle 0, out_valid rises at cycle 2+n.
REQ-015 SHALL, in DONE, hold out_valid=1 and stable outputs until out_valid && out_ready, then return to IDLE on the next cycle.
REQ-016 SHALL never accept a new request before the previous result is consumed; there is no overlap.
REQ-017 SHALL, when divisor==0, produce quotient all-ones, remainder=dividend, and div_by_zero=1; otherwise div_by_zero=0.
REQ-018 SHALL produce quotient=0 and remainder=dividend when dividend<divisor.
REQ-019 SHALL produce out_tag equal to the in_tag captured at acceptance.
REQ-020 SHALL ignore in_valid while not in IDLE.

Reset
REQ-021 SHALL, on rst, enter IDLE with in_ready=1, out_valid=0, quotient=0, remainder=0, out_tag=0, div_by_zero=0, and the iteration counter=0.
REQ-022 SHALL, on rst asserted mid-ITER or in DONE, abort the operation, produce no out_valid pulse, and make in_ready=1 on the first cycle after rst deasserts.
REQ-023 SHALL give rst priority over every handshake on the same cycle.

Configuration
REQ-024 SHALL support macro DIV_ITER_SIGNED_EN.
REQ-025 SHALL, when DIV_ITER_SIGNED_EN is defined, treat operands as two's complement and divide magnitudes, with:
- quotient truncated toward zero;
- remainder taking the sign of the dividend;
- most-negative / -1 giving quotient=most-negative, remainder=0;
- divide by zero giving quotient all-ones, remainder=dividend.
REQ-026 SHALL, when DIV_ITER_SIGNED_EN is undefined, treat operands as unsigned, add no sign logic, and keep ports and latency per REQ-014.
REQ-027 SHALL compute n in signed mode from the dividend magnitude.

Structure
REQ-028 SHALL place the FSM state enum and the counter-width constant $clog2(D_W+1) in shared package div_pkg.
REQ-029 SHALL implement the highest-set-bit search as combinational sub-module div_msb_find, parameterised by D_W.

Verification
REQ-030 SHALL cover: D_W=32, 100/7 -> quotient 14, remainder 2, out_valid at cycle 9 (n=7).
REQ-031 SHALL cover: 5/9 -> quotient 0, remainder 5; 0/3 -> quotient 0, remainder 0, out_valid at cycle 2.
REQ-032 SHALL cover: 1234/0 -> quotient 0xFFFFFFFF, remainder 1234, div_by_zero=1, out_valid at cycle 2.
REQ-033 SHALL cover: 0xFFFFFFFF/1 with out_ready held low 5 cycles -> quotient 0xFFFFFFFF, outputs stable, in_ready=0 throughout, tag preserved.
REQ-034 SHALL cover: rst pulsed at cycle 4 of a 32-iteration divide -> no out_valid, then a following 100/7 gives 14 r 2.
REQ-035 SHALL cover, with DIV_ITER_SIGNED_EN: -100/7 -> quotient -14, remainder -2; 0x80000000/-1 -> quotient 0x80000000, remainder 0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding and counter sizing.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ITER,
        DONE
    } state_t;

    // Iteration counter must hold 0..D_W inclusive.
    function automatic int cnt_width(input int d_w);
        return $clog2(d_w + 1);
    endfunction

    localparam int CNT_W_DEFAULT = $clog2(32 + 1);

endpackage

// File: rtl/div_msb_find.sv
// Combinational highest-set-bit search: n = index of top set bit + 1, or 0 for a zero input.
module div_msb_find
    import div_pkg::*;
#(
    parameter  int D_W   = 32,
    localparam int CNT_W = cnt_width(D_W)
) (
    input  logic [D_W-1:0]   value,
    output logic [CNT_W-1:0] n
);

    // Later (higher) bits overwrite earlier hits, so the last match wins.
    always_comb begin
        n = '0;
        for (int i = 0; i < D_W; i++) begin
            if (value[i]) begin
                n = CNT_W'(i + 1);
            end
        end
    end

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle over significant dividend bits only.
// Define DIV_ITER_SIGNED_EN for two's-complement operands (magnitude divide plus sign fix-up).
module div_iter
    import div_pkg::*;
#(
    parameter  int D_W   = 32,
    parameter  int TAG_W = 4,
    localparam int CNT_W = cnt_width(D_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [D_W-1:0]   dividend,
    input  logic [D_W-1:0]   divisor,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [D_W-1:0]   quotient,
    output logic [D_W-1:0]   remainder,
    output logic [TAG_W-1:0] out_tag,
    output logic             div_by_zero
);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [D_W-1:0]   dvd_raw_reg;
    logic [D_W-1:0]   dvd_mag_reg;
    logic [D_W-1:0]   dvs_mag_reg;
`ifdef DIV_ITER_SIGNED_EN
    logic             neg_q_reg;
    logic             neg_r_reg;
`endif

    logic [CNT_W-1:0] msb_n;
    logic [D_W-1:0]   bit_window;
    logic [D_W:0]     pr;
    logic [D_W:0]     pr_sub;
    logic             pr_ge;
    logic [D_W-1:0]   q_step;
    logic [D_W-1:0]   r_step;
    logic [D_W-1:0]   q_fix;
    logic [D_W-1:0]   r_fix;

    div_msb_find #(.D_W(D_W)) u_msb_find (
        .value (dvd_mag_reg),
        .n     (msb_n)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = LOAD;
            end
            LOAD: begin
                if (msb_n != '0 && dvs_mag_reg != '0) state_next = ITER;
                else                                  state_next = DONE;
            end
            ITER: begin
                if (cnt_reg == CNT_W'(1)) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // One restoring step: shift in dividend bit cnt-1, subtract when it fits.
    always_comb begin
        bit_window = dvd_mag_reg >> (cnt_reg - CNT_W'(1));
        pr         = {remainder, bit_window[0]};
        pr_sub     = pr - {1'b0, dvs_mag_reg};
        pr_ge      = (pr >= {1'b0, dvs_mag_reg});
        r_step     = pr_ge ? pr_sub[D_W-1:0] : pr[D_W-1:0];
        q_step     = {quotient[D_W-2:0], pr_ge};
`ifdef DIV_ITER_SIGNED_EN
        q_fix      = neg_q_reg ? (D_W'(0) - q_step) : q_step;
        r_fix      = neg_r_reg ? (D_W'(0) - r_step) : r_step;
`else
        q_fix      = q_step;
        r_fix      = r_step;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg     <= '0;
            dvd_raw_reg <= '0;
            dvd_mag_reg <= '0;
            dvs_mag_reg <= '0;
            quotient    <= '0;
            remainder   <= '0;
            out_tag     <= '0;
            div_by_zero <= 1'b0;
`ifdef DIV_ITER_SIGNED_EN
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        dvd_raw_reg <= dividend;
                        out_tag     <= in_tag;
`ifdef DIV_ITER_SIGNED_EN
                        dvd_mag_reg <= dividend[D_W-1] ? (D_W'(0) - dividend) : dividend;
                        dvs_mag_reg <= divisor[D_W-1]  ? (D_W'(0) - divisor)  : divisor;
                        neg_q_reg   <= dividend[D_W-1] ^ divisor[D_W-1];
                        neg_r_reg   <= dividend[D_W-1];
`else
                        dvd_mag_reg <= dividend;
                        dvs_mag_reg <= divisor;
`endif
                    end
                end
                LOAD: begin
                    cnt_reg     <= msb_n;
                    div_by_zero <= (dvs_mag_reg == '0);
                    if (dvs_mag_reg == '0) begin
                        quotient  <= '1;
                        remainder <= dvd_raw_reg;
                    end else begin
                        // Zero dividend skips ITER entirely, so 0 is already the final answer.
                        quotient  <= '0;
                        remainder <= '0;
                    end
                end
                ITER: begin
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) begin
                        quotient  <= q_fix;
                        remainder <= r_fix;
                    end else begin
                        quotient  <= q_step;
                        remainder <= r_step;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Directed self-checking bench for div_iter (D_W=32); signed vectors added when DIV_ITER_SIGNED_EN is defined.
module tb_div_iter;

    localparam int D_W   = 32;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [D_W-1:0]   dividend;
    logic [D_W-1:0]   divisor;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [D_W-1:0]   quotient;
    logic [D_W-1:0]   remainder;
    logic [TAG_W-1:0] out_tag;
    logic             div_by_zero;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    div_iter #(.D_W(D_W), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .out_tag     (out_tag),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Issue one request, measure latency from the accept cycle, hold out_ready low for
    // 'hold' cycles (while poking in_valid, which must be ignored), then consume.
    task automatic do_div(input string name, input logic [D_W-1:0] a, input logic [D_W-1:0] b,
                          input logic [TAG_W-1:0] tag, input logic [D_W-1:0] exp_q,
                          input logic [D_W-1:0] exp_r, input logic exp_dbz,
                          input int exp_lat, input int hold);
        int cyc;
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        in_tag    = tag;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        check({name, ".in_ready_idle"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = ~a;
        divisor  = ~b;
        in_tag   = ~tag;
        cyc = 1;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({name, ".latency"}, 64'(cyc), 64'(exp_lat));
        check({name, ".quotient"}, 64'(quotient), 64'(exp_q));
        check({name, ".remainder"}, 64'(remainder), 64'(exp_r));
        check({name, ".div_by_zero"}, 64'(div_by_zero), 64'(exp_dbz));
        check({name, ".out_tag"}, 64'(out_tag), 64'(tag));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            check({name, ".hold_valid"}, 64'(out_valid), 64'd1);
            check({name, ".hold_in_ready"}, 64'(in_ready), 64'd0);
            check({name, ".hold_quotient"}, 64'(quotient), 64'(exp_q));
            check({name, ".hold_remainder"}, 64'(remainder), 64'(exp_r));
            check({name, ".hold_tag"}, 64'(out_tag), 64'(tag));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, ".consumed_valid"}, 64'(out_valid), 64'd0);
        check({name, ".consumed_in_ready"}, 64'(in_ready), 64'd1);
        $display("div %s: %0h / %0h -> q=%0h r=%0h dbz=%0b tag=%0h latency=%0d",
                 name, a, b, quotient, remainder, div_by_zero, out_tag, cyc);
    endtask

    initial begin
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        in_tag    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.in_ready", 64'(in_ready), 64'd1);
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.quotient", 64'(quotient), 64'd0);
        check("reset.remainder", 64'(remainder), 64'd0);
        check("reset.out_tag", 64'(out_tag), 64'd0);
        check("reset.div_by_zero", 64'(div_by_zero), 64'd0);
        rst = 1'b0;

        do_div("100/7",    32'd100,  32'd7,  4'h3, 32'd14, 32'd2,    1'b0, 9,  0);
        do_div("5/9",      32'd5,    32'd9,  4'h5, 32'd0,  32'd5,    1'b0, 5,  0);
        do_div("0/3",      32'd0,    32'd3,  4'h6, 32'd0,  32'd0,    1'b0, 2,  0);
        do_div("1234/0",   32'd1234, 32'd0,  4'h9, 32'hFFFFFFFF, 32'd1234, 1'b1, 2, 0);
        do_div("1000/10",  32'd1000, 32'd10, 4'hA, 32'd100, 32'd0,   1'b0, 12, 0);
`ifdef DIV_ITER_SIGNED_EN
        do_div("ffffffff/1", 32'hFFFFFFFF, 32'd1, 4'hC, 32'hFFFFFFFF, 32'd0, 1'b0, 3, 5);
`else
        do_div("ffffffff/1", 32'hFFFFFFFF, 32'd1, 4'hC, 32'hFFFFFFFF, 32'd0, 1'b0, 34, 5);
`endif

        // Abort a 32-iteration divide with rst during cycle 4.
        @(negedge clk);
        dividend = 32'h80000000;
        divisor  = 32'd3;
        in_tag   = 4'hE;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort.in_ready", 64'(in_ready), 64'd1);
        check("abort.quotient", 64'(quotient), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        check("abort.no_out_valid", 64'(seen), 64'd0);
        $display("abort: rst at cycle 4, out_valid cycles seen afterwards=%0d", seen);
        do_div("100/7_after_abort", 32'd100, 32'd7, 4'h1, 32'd14, 32'd2, 1'b0, 9, 0);

`ifdef DIV_ITER_SIGNED_EN
        do_div("-100/7", 32'hFFFFFF9C, 32'd7, 4'h2, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 9, 0);
        do_div("min/-1", 32'h80000000, 32'hFFFFFFFF, 4'h4, 32'h80000000, 32'd0, 1'b0, 34, 0);
        do_div("-7/0",   32'hFFFFFFF9, 32'd0, 4'h7, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 2, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
